// File: rtl/isp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// isp_mode_ctrl
//
// Lets an operator choose the processing mode of four ISP stages (first,
// second, edge, after-edge) with two push buttons. The rgb_sw switches pick
// the stage that the buttons edit. Edits go into shadow registers and are
// copied to the applied selects only at the start of a frame, so the picture
// never changes mode part-way through a frame. rgb_sw[0] forces every stage
// into bypass (mode 0) without disturbing any stored state.
//
// Ports
//   clk          : single clock, all state on the rising edge
//   reset        : asynchronous, active-high
//   rgb_sw[4:0]  : [0] global bypass, [4:1] stage target (lowest set bit wins)
//   btn[1:0]     : raw asynchronous buttons, [0] up, [1] down
//   x_coor[9:0]  : current pixel column
//   y_coor[8:0]  : current pixel row
//   oe           : display enable for the current pixel
//   sel_first, sel_second, sel_edge, sel_after [2:0] : applied mode per stage
//   active_stage[1:0] : stage currently edited by the buttons
//   stage_valid  : some stage-target switch is on
//   pending      : some shadow select is waiting for the next frame start
// ---------------------------------------------------------------------------
module isp_mode_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int NUM_MODES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rgb_sw,
    input  logic [1:0] btn,
    input  logic [9:0] x_coor,
    input  logic [8:0] y_coor,
    input  logic       oe,
    output logic [2:0] sel_first,
    output logic [2:0] sel_second,
    output logic [2:0] sel_edge,
    output logic [2:0] sel_after,
    output logic [1:0] active_stage,
    output logic       stage_valid,
    output logic       pending
);

    typedef enum logic [1:0] {
        STAGE_FIRST  = 2'd0,
        STAGE_SECOND = 2'd1,
        STAGE_EDGE   = 2'd2,
        STAGE_AFTER  = 2'd3
    } stage_e;

    localparam int              CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [2:0]      MODE_LAST = 3'(NUM_MODES - 1);

    // ------------------------------------------------------------------
    // Button synchronizers
    // ------------------------------------------------------------------
    logic [1:0] sync_q1, sync_q2;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its source, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the accepted level flips only after DB_CYCLES consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       db_level, db_level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
            db_level   <= '0;
            db_level_d <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] != db_level[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        db_level[i] <= sync_q2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            db_level_d <= db_level;
        end
    end

    // One-cycle pulse on each accepted press; simultaneous presses cancel.
    logic [1:0] rise;
    logic       up_pulse, down_pulse;

    assign rise       = db_level & ~db_level_d;
    assign up_pulse   = rise[0] & ~rise[1];
    assign down_pulse = rise[1] & ~rise[0];

    // ------------------------------------------------------------------
    // Stage target: lowest-index switch wins; with no switch on, the last
    // target is remembered and the buttons do nothing.
    // ------------------------------------------------------------------
    stage_e stage_enc, last_stage;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        stage_enc = STAGE_AFTER;
        if (rgb_sw[1])      stage_enc = STAGE_FIRST;
        else if (rgb_sw[2]) stage_enc = STAGE_SECOND;
        else if (rgb_sw[3]) stage_enc = STAGE_EDGE;
    end

    assign stage_valid = |rgb_sw[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            last_stage <= STAGE_FIRST;
        else if (stage_valid) last_stage <= stage_enc;
    end

    assign active_stage = stage_valid ? stage_enc : last_stage;

    // ------------------------------------------------------------------
    // Frame start: rising edge of "first visible pixel".
    // ------------------------------------------------------------------
    logic frame_cond, frame_cond_d, frame_start;

    assign frame_cond  = oe && (x_coor == 10'd0) && (y_coor == 9'd0);
    assign frame_start = frame_cond && !frame_cond_d;

    // ------------------------------------------------------------------
    // Shadow and applied selects. The commit reads the shadow's pre-edge
    // value, so an edit landing in the frame-start cycle waits one frame.
    // ------------------------------------------------------------------
    logic [2:0] shadow  [4];
    logic [2:0] applied [4];

    // NOTE: the select arrays are small register files whose reset value is
    // visible on the outputs, so they are reset explicitly, element by element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cond_d <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i]  <= '0;
                applied[i] <= '0;
            end
        end else begin
            frame_cond_d <= frame_cond;
            if (stage_valid && up_pulse) begin
                shadow[active_stage] <= (shadow[active_stage] == MODE_LAST)
                                        ? 3'd0 : shadow[active_stage] + 3'd1;
            end else if (stage_valid && down_pulse) begin
                shadow[active_stage] <= (shadow[active_stage] == 3'd0)
                                        ? MODE_LAST : shadow[active_stage] - 3'd1;
            end
            if (frame_start) begin
                for (int i = 0; i < 4; i++) applied[i] <= shadow[i];
            end
        end
    end

    assign pending = (shadow[0] != applied[0]) || (shadow[1] != applied[1]) ||
                     (shadow[2] != applied[2]) || (shadow[3] != applied[3]);

    // Bypass masks the outputs only; stored selects are untouched.
    assign sel_first  = rgb_sw[0] ? 3'd0 : applied[STAGE_FIRST];
    assign sel_second = rgb_sw[0] ? 3'd0 : applied[STAGE_SECOND];
    assign sel_edge   = rgb_sw[0] ? 3'd0 : applied[STAGE_EDGE];
    assign sel_after  = rgb_sw[0] ? 3'd0 : applied[STAGE_AFTER];

endmodule

// File: tb/tb_isp_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isp_mode_ctrl
//
// Directed bench for isp_mode_ctrl with DB_CYCLES=4. Inputs change 1 ns after
// a rising edge and outputs are checked at that same point. With that timing
// a button set after edge k yields its pulse in the cycle after edge k+6
// (2 synchronizer edges + 4 debounce samples).
// ---------------------------------------------------------------------------
module tb_isp_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rgb_sw;
    logic [1:0] btn;
    logic [9:0] x_coor;
    logic [8:0] y_coor;
    logic       oe;
    logic [2:0] sel_first, sel_second, sel_edge, sel_after;
    logic [1:0] active_stage;
    logic       stage_valid, pending;

    int n_cmp = 0;
    int n_err = 0;

    isp_mode_ctrl #(.DB_CYCLES(4), .NUM_MODES(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rgb_sw       (rgb_sw),
        .btn          (btn),
        .x_coor       (x_coor),
        .y_coor       (y_coor),
        .oe           (oe),
        .sel_first    (sel_first),
        .sel_second   (sel_second),
        .sel_edge     (sel_edge),
        .sel_after    (sel_after),
        .active_stage (active_stage),
        .stage_valid  (stage_valid),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a button pattern long enough for one accepted press, then release
    // and let the release debounce too.
    task automatic press(input logic [1:0] b);
        btn = b;
        repeat (10) step();
        btn = 2'b00;
        repeat (8) step();
    endtask

    // Present the first visible pixel for one cycle; the commit lands on the
    // edge that ends this cycle.
    task automatic frame();
        oe = 1'b1; x_coor = 10'd0; y_coor = 9'd0;
        step();
        oe = 1'b0; x_coor = 10'd5; y_coor = 9'd5;
    endtask

    initial begin
        reset  = 1'b1;
        rgb_sw = 5'b00000;
        btn    = 2'b00;
        oe     = 1'b0;
        x_coor = 10'd5;
        y_coor = 9'd5;
        #2;
        check("rst_sel_first",  sel_first,    0);
        check("rst_sel_second", sel_second,   0);
        check("rst_sel_edge",   sel_edge,     0);
        check("rst_sel_after",  sel_after,    0);
        check("rst_active",     active_stage, 0);
        check("rst_pending",    pending,      0);
        check("rst_valid",      stage_valid,  0);
        step();
        step();
        reset = 1'b0;
        step();

        // Stage "second": one held up press, committed at frame start.
        rgb_sw = 5'b00100;
        #1;
        check("sec_valid",  stage_valid,  1);
        check("sec_active", active_stage, 1);
        press(2'b01);
        check("sec_pend_before", pending,    1);
        check("sec_sel_before",  sel_second, 0);
        oe = 1'b1; x_coor = 10'd0; y_coor = 9'd0;
        #1;
        check("sec_sel_in_fs_cycle", sel_second, 0);
        step();
        oe = 1'b0; x_coor = 10'd5; y_coor = 9'd5;
        check("sec_sel_after", sel_second, 1);
        check("sec_pend_after", pending,   0);
        check("sec_first_0",   sel_first,  0);
        check("sec_edge_0",    sel_edge,   0);
        check("sec_after_0",   sel_after,  0);

        // Stage "edge": down from 0 wraps to 4; five ups return to 4.
        rgb_sw = 5'b01000;
        #1;
        check("edge_active", active_stage, 2);
        press(2'b10);
        check("edge_pend_dn", pending, 1);
        frame();
        check("edge_wrap_dn", sel_edge, 4);
        repeat (5) press(2'b01);
        check("edge_pend_5up", pending, 0);
        frame();
        check("edge_after_5up", sel_edge, 4);

        // Glitch and simultaneous presses on stage "first".
        rgb_sw = 5'b00010;
        btn = 2'b01;
        repeat (2) step();
        btn = 2'b00;
        repeat (10) step();
        check("glitch_pend", pending, 0);
        press(2'b11);
        check("both_pend", pending, 0);
        frame();
        check("both_sel_first", sel_first, 0);

        // Up pulse lands in the frame-start cycle: deferred one frame.
        btn = 2'b01;
        repeat (6) step();
        oe = 1'b1; x_coor = 10'd0; y_coor = 9'd0;
        step();
        oe = 1'b0; x_coor = 10'd5; y_coor = 9'd5;
        check("coinc_sel",  sel_first, 0);
        check("coinc_pend", pending,   1);
        btn = 2'b00;
        repeat (8) step();
        frame();
        check("coinc_sel_next",  sel_first, 1);
        check("coinc_pend_next", pending,   0);

        // Stage "after" to 3, then bypass on/off without a clock edge.
        rgb_sw = 5'b10000;
        #1;
        check("after_active", active_stage, 3);
        repeat (3) press(2'b01);
        frame();
        check("after_sel", sel_after, 3);
        rgb_sw = 5'b10001;
        #1;
        check("byp_after",  sel_after,  0);
        check("byp_second", sel_second, 0);
        check("byp_pend",   pending,    0);
        rgb_sw = 5'b10000;
        #1;
        check("unbyp_after",  sel_after,  3);
        check("keep_first",   sel_first,  1);
        check("keep_second",  sel_second, 1);
        check("keep_edge",    sel_edge,   4);

        // No target switch: stage held, presses ignored.
        rgb_sw = 5'b00000;
        #1;
        check("none_valid",  stage_valid,  0);
        check("none_active", active_stage, 3);
        press(2'b01);
        check("none_pend", pending, 0);

        // Asynchronous reset with an edit pending and a press mid-debounce.
        rgb_sw = 5'b00010;
        press(2'b01);
        frame();
        check("pre_rst_sel_first", sel_first, 2);
        press(2'b01);
        check("pre_rst_pend", pending, 1);
        btn = 2'b01;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_sel_first",  sel_first,  0);
        check("arst_sel_second", sel_second, 0);
        check("arst_sel_edge",   sel_edge,   0);
        check("arst_sel_after",  sel_after,  0);
        check("arst_pend",       pending,    0);
        step();
        step();
        reset = 1'b0;
        repeat (20) step();
        check("held_pend", pending, 1);
        btn = 2'b00;
        repeat (8) step();
        frame();
        check("held_one_pulse", sel_first, 1);
        check("held_pend_after", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
